i2c_target_regfile: RTL
=======================

Name: i2c_target_regfile

Overview:
- I2C target (responder) holding a 256x8 register file; the counterpart of the team's HDMI init I2C master.
- Used as an on-board stand-in for the HDMI transmitter's register map, and as the bench responder that checks the init sequence.
- Supports single and burst writes, and combined write-pointer/repeated-START/read transfers with auto-increment.
- Oversamples SCL/SDA on the 50 MHz system clock; no clock stretching.

Parameters:
- DEV_ADDR, 7'h39, 7-bit target address (write byte 0x72, read byte 0x73).
- SYNC_STAGES, 2, flip-flop stages synchronising i2c_scl and i2c_sda; minimum 2.

Ports:
- clk_ref  input  1  system clock, 50 MHz; must be at least 16x SCL frequency.
- reset_n  input  1  asynchronous, active-low reset.
- i2c_scl  input  1  bus clock from the master.
- i2c_sda  inout  1  open-drain data; driven to 1'b0 only when pulling low, otherwise 1'bz.
- addressed  output  1  high from the address ACK until STOP, repeated START or NACK.
- wr_strobe  output  1  one-cycle pulse per register write.
- wr_addr  output  8  register written; valid with wr_strobe.
- wr_data  output  8  data written; valid with wr_strobe.
- dbg_addr  input  8  observation read address.
- dbg_data  output  8  regfile[dbg_addr], registered, 1-cycle latency.

Behaviour:
Reset:
- State IDLE; SDA released; pointer = 0.
- addressed, wr_strobe, wr_addr, wr_data and dbg_data all 0.
- Register file contents are not reset (RAM-inferable).

Edge detection:
- SCL rise/fall and SDA rise/fall come from the last two synchronised samples.
- START (SDA falls while SCL high) has priority over every other event in the same cycle.
- START from any state -> ADDR; bit count = 0; SDA released.
- STOP (SDA rises while SCL high) from any state -> IDLE; SDA released.
- A partial byte is discarded: no write, no pointer change.

Bit timing:
- SDA is sampled on SCL rise.
- The target changes SDA only on the clk_ref cycle after an SCL fall.

States:
- IDLE: wait for START.
- ADDR: shift 8 bits, MSB first. On the 8th rise, bits[7:1] == DEV_ADDR -> ADDR_ACK; otherwise -> IGNORE.
- IGNORE: SDA never driven; wait for START or STOP.
- ADDR_ACK: on the SCL fall after bit 8, drive SDA low and set addressed. On the next fall, release SDA.
  - R/W = 0 -> REG.
  - R/W = 1 -> load shift register with regfile[ptr], then RDATA.
- REG: shift 8 bits; load the pointer on the 8th rise -> REG_ACK.
- REG_ACK: ACK driven as in ADDR_ACK -> WDATA.
- WDATA: on the 8th rise, write regfile[ptr]; wr_strobe = 1 for one cycle with wr_addr = ptr and wr_data = byte; ptr += 1 -> WDATA_ACK.
- WDATA_ACK: ACK driven -> WDATA.
- RDATA: drive SDA low when the current bit is 0, release when 1; advance bits on SCL falls. After the 8th bit's fall, release SDA -> RACK.
- RACK: sample the master's bit on the 9th rise; ptr += 1.
  - 0 (ACK): on the next fall load regfile[ptr] and drive the MSB -> RDATA.
  - 1 (NACK): clear addressed -> IGNORE.

Pointer and register file:
- Pointer is 8-bit and wraps 0xFF -> 0x00 in both directions.
- A register-pointer write with no data byte only sets the pointer.
- dbg_data is registered every cycle from regfile[dbg_addr].
- A write and a debug read of the same address in the same cycle return the old value.

Asynchronous reset during a transfer:
- SDA is released immediately and state returns to IDLE.
- The transfer in progress is abandoned; the master sees a NACK or bus error.

Decomposition:
- Shared package i2c_pkg:
  - state encodings (IDLE, ADDR, IGNORE, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RACK);
  - default HDMI transmitter address 7'h39.
- Sub-module i2c_bus_sync:
  - SYNC_STAGES synchroniser for SCL/SDA;
  - outputs one-cycle scl_rise, scl_fall, start_det and stop_det pulses.

Test Plan:
- Write 0x72, 0x98, 0x03, STOP -> ACK on all 3 bytes; one wr_strobe with wr_addr 0x98, wr_data 0x03; dbg_addr 0x98 gives dbg_data 0x03 one cycle later.
- Burst 0x72, 0xFE, 0xAA, 0xBB, 0xCC, STOP -> writes FE=AA, FF=BB, 00=CC (wrap); 3 strobes.
- Combined read 0x72, 0x98, Sr, 0x73, read 2 bytes (master ACK, then NACK) -> returns 0x03, then regfile[0x99]; pointer ends 0x9A; SDA released after the NACK; addressed drops.
- Address 0x74, then 0x10, 0x55 -> SDA high on every 9th clock; no wr_strobe; addressed stays 0.
- STOP after 4 bits of a data byte -> no write; the next single write to 0x20 succeeds.
- reset_n pulsed low while the target drives a 0 read bit -> i2c_sda goes Z immediately; state IDLE; the following full write transaction ACKs normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-file target: FSM encodings,
// default device address and a small address-match helper.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      IGNORE,
      ADDR_ACK,
      REG,
      REG_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RACK
   } i2c_state_t;

   // Default HDMI transmitter address (write byte 0x72, read byte 0x73)
   localparam logic [6:0] HDMI_TX_ADDR = 7'h39;

   localparam logic [2:0] LAST_BIT = 3'd7;

   function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev);
      return addr_byte[7:1] == dev;
   endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into clk_ref and derives one-cycle edge, START and
// STOP pulses from the last two synchronised samples of each line.
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_ref,
   input  logic reset_n,
   input  logic scl_raw,
   input  logic sda_raw,
   output logic sda_level,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   localparam int SCL_IDX = 1;
   localparam int SDA_IDX = 0;

   logic [1:0] line_raw;
   logic [1:0] line_now;
   logic [1:0] line_prev;
   logic       scl_high;

   assign line_raw = {scl_raw, sda_raw};

   // One extra flop beyond the synchroniser holds the previous sample.
   // Reset to 1 so an idle (pulled-up) bus produces no edges at reset release.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_line
         logic [SYNC_STAGES:0] chain_reg;

         always_ff @(posedge clk_ref or negedge reset_n) begin
            if (!reset_n) begin
               chain_reg <= '1;
            end else begin
               chain_reg <= {chain_reg[SYNC_STAGES-1:0], line_raw[gi]};
            end
         end

         assign line_now[gi]  = chain_reg[SYNC_STAGES-1];
         assign line_prev[gi] = chain_reg[SYNC_STAGES];
      end
   endgenerate

   assign scl_high  = line_now[SCL_IDX] & line_prev[SCL_IDX];
   assign sda_level = line_now[SDA_IDX];
   assign scl_rise  = line_now[SCL_IDX] & ~line_prev[SCL_IDX];
   assign scl_fall  = ~line_now[SCL_IDX] & line_prev[SCL_IDX];
   assign start_det = scl_high & line_prev[SDA_IDX] & ~line_now[SDA_IDX];
   assign stop_det  = scl_high & ~line_prev[SDA_IDX] & line_now[SDA_IDX];

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target exposing a 256x8 register file with an auto-incrementing pointer;
// supports single/burst writes and pointer-write + repeated-START reads.
module i2c_target_regfile
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = HDMI_TX_ADDR,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk_ref,
   input  logic       reset_n,
   input  logic       i2c_scl,
   inout  wire        i2c_sda,
   output logic       addressed,
   output logic       wr_strobe,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   input  logic [7:0] dbg_addr,
   output logic [7:0] dbg_data
);

   logic sda_level;
   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;

   i2c_bus_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_ref   (clk_ref),
      .reset_n   (reset_n),
      .scl_raw   (i2c_scl),
      .sda_raw   (i2c_sda),
      .sda_level (sda_level),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   i2c_state_t state_reg, state_next;
   logic [2:0] bit_cnt_reg, bit_cnt_next;
   logic [7:0] shift_reg, shift_next;
   logic [7:0] ptr_reg, ptr_next;
   logic       rw_reg, rw_next;
   logic       ack_phase_reg, ack_phase_next;
   logic       sda_low_reg, sda_low_next;
   logic       addressed_reg, addressed_next;
   logic       wr_strobe_reg, wr_strobe_next;
   logic [7:0] wr_addr_reg, wr_addr_next;
   logic [7:0] wr_data_reg, wr_data_next;
   logic [7:0] rd_data_reg;
   logic [7:0] dbg_data_reg;
   logic       mem_we;
   logic [7:0] byte_in;
   logic       last_bit;

   logic [7:0] mem [0:255];

   assign byte_in  = {shift_reg[6:0], sda_level};
   assign last_bit = (bit_cnt_reg == LAST_BIT);

   always_ff @(posedge clk_ref or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         bit_cnt_reg   <= '0;
         shift_reg     <= '0;
         ptr_reg       <= '0;
         rw_reg        <= 1'b0;
         ack_phase_reg <= 1'b0;
         sda_low_reg   <= 1'b0;
         addressed_reg <= 1'b0;
         wr_strobe_reg <= 1'b0;
         wr_addr_reg   <= '0;
         wr_data_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         bit_cnt_reg   <= bit_cnt_next;
         shift_reg     <= shift_next;
         ptr_reg       <= ptr_next;
         rw_reg        <= rw_next;
         ack_phase_reg <= ack_phase_next;
         sda_low_reg   <= sda_low_next;
         addressed_reg <= addressed_next;
         wr_strobe_reg <= wr_strobe_next;
         wr_addr_reg   <= wr_addr_next;
         wr_data_reg   <= wr_data_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      bit_cnt_next   = bit_cnt_reg;
      shift_next     = shift_reg;
      ptr_next       = ptr_reg;
      rw_next        = rw_reg;
      ack_phase_next = ack_phase_reg;
      sda_low_next   = sda_low_reg;
      addressed_next = addressed_reg;
      wr_strobe_next = 1'b0;
      wr_addr_next   = wr_addr_reg;
      wr_data_next   = wr_data_reg;
      mem_we         = 1'b0;

      if (start_det) begin
         state_next     = ADDR;
         bit_cnt_next   = '0;
         ack_phase_next = 1'b0;
         sda_low_next   = 1'b0;
         addressed_next = 1'b0;
      end else if (stop_det) begin
         state_next     = IDLE;
         ack_phase_next = 1'b0;
         sda_low_next   = 1'b0;
         addressed_next = 1'b0;
      end else begin
         case (state_reg)
            IDLE, IGNORE: begin
            end

            ADDR, REG, WDATA: begin
               if (scl_rise) begin
                  shift_next   = byte_in;
                  bit_cnt_next = bit_cnt_reg + 3'd1;
                  if (last_bit) begin
                     if (state_reg == ADDR) begin
                        rw_next    = sda_level;
                        state_next = addr_match(byte_in, DEV_ADDR) ? ADDR_ACK : IGNORE;
                     end else if (state_reg == REG) begin
                        ptr_next   = byte_in;
                        state_next = REG_ACK;
                     end else begin
                        mem_we         = 1'b1;
                        wr_strobe_next = 1'b1;
                        wr_addr_next   = ptr_reg;
                        wr_data_next   = byte_in;
                        ptr_next       = ptr_reg + 8'd1;
                        state_next     = WDATA_ACK;
                     end
                  end
               end
            end

            // First fall after bit 8 pulls SDA low; the following fall ends the ACK.
            ADDR_ACK, REG_ACK, WDATA_ACK: begin
               if (scl_fall) begin
                  if (!ack_phase_reg) begin
                     sda_low_next   = 1'b1;
                     ack_phase_next = 1'b1;
                     if (state_reg == ADDR_ACK) begin
                        addressed_next = 1'b1;
                     end
                  end else begin
                     sda_low_next   = 1'b0;
                     ack_phase_next = 1'b0;
                     bit_cnt_next   = '0;
                     if (state_reg == ADDR_ACK && rw_reg) begin
                        shift_next   = rd_data_reg;
                        sda_low_next = ~rd_data_reg[7];
                        state_next   = RDATA;
                     end else if (state_reg == ADDR_ACK) begin
                        state_next = REG;
                     end else begin
                        state_next = WDATA;
                     end
                  end
               end
            end

            RDATA: begin
               if (scl_fall) begin
                  if (last_bit) begin
                     sda_low_next = 1'b0;
                     bit_cnt_next = '0;
                     state_next   = RACK;
                  end else begin
                     shift_next   = {shift_reg[6:0], 1'b0};
                     sda_low_next = ~shift_reg[6];
                     bit_cnt_next = bit_cnt_reg + 3'd1;
                  end
               end
            end

            // ack_phase marks a master ACK seen, waiting for the fall to send the next byte.
            RACK: begin
               if (scl_rise && !ack_phase_reg) begin
                  ptr_next = ptr_reg + 8'd1;
                  if (sda_level) begin
                     addressed_next = 1'b0;
                     state_next     = IGNORE;
                  end else begin
                     ack_phase_next = 1'b1;
                  end
               end else if (scl_fall && ack_phase_reg) begin
                  ack_phase_next = 1'b0;
                  shift_next     = rd_data_reg;
                  sda_low_next   = ~rd_data_reg[7];
                  bit_cnt_next   = '0;
                  state_next     = RDATA;
               end
            end

            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // rd_data tracks regfile[ptr] continuously so a read byte is ready at the ACK fall.
   always_ff @(posedge clk_ref) begin
      if (mem_we) begin
         mem[ptr_reg] <= byte_in;
      end
      rd_data_reg <= mem[ptr_reg];
   end

   always_ff @(posedge clk_ref or negedge reset_n) begin
      if (!reset_n) begin
         dbg_data_reg <= '0;
      end else begin
         dbg_data_reg <= mem[dbg_addr];
      end
   end

   assign i2c_sda   = sda_low_reg ? 1'b0 : 1'bz;
   assign addressed = addressed_reg;
   assign wr_strobe = wr_strobe_reg;
   assign wr_addr   = wr_addr_reg;
   assign wr_data   = wr_data_reg;
   assign dbg_data  = dbg_data_reg;

endmodule
